// File: rtl/phy_rx_deframer_if.sv
// Stream signals of phy_rx_deframer: raw PHY word input plus framed payload output.
// master = upstream PHY / downstream MAC environment, slave = the deframer itself.
interface phy_rx_deframer_if;
  logic        in_valid;
  logic [15:0] data_in;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] data_out;
  logic        out_sof;
  logic        out_eof;
  logic        locked;
  logic        frame_err;
  logic        overflow;

  modport master (
    output in_valid, data_in, out_ready,
    input  out_valid, data_out, out_sof, out_eof, locked, frame_err, overflow
  );

  modport slave (
    input  in_valid, data_in, out_ready,
    output out_valid, data_out, out_sof, out_eof, locked, frame_err, overflow
  );
endinterface

// File: rtl/phy_rx_deframer.sv
// RX deframer: hunts for SYNC_WORD, parses a length header, pushes payload into an output FIFO.
// Optional trailing CRC-16-CCITT check is built when PHY_RX_CRC_CHECK_EN is defined.
module phy_rx_deframer #(
  parameter logic [15:0] SYNC_WORD  = 16'hA5C3,
  parameter int          MAX_LEN    = 64,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  phy_rx_deframer_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(MAX_LEN + 1);

`ifdef PHY_RX_CRC_CHECK_EN
  typedef enum logic [1:0] {S_HUNT, S_HEADER, S_PAYLOAD, S_CRC} state_t;
`else
  typedef enum logic [1:0] {S_HUNT, S_HEADER, S_PAYLOAD} state_t;
`endif

  typedef struct packed {
    logic        sof;
    logic        eof;
    logic [15:0] data;
  } entry_t;

  state_t             state_q, state_d;
  logic               locked_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               first_q, first_d;
  logic               frame_err_q, err_d;
  logic               overflow_q;
  logic [PTR_W:0]     wr_ptr_q, rd_ptr_q;
  entry_t             mem [FIFO_DEPTH];

  logic               len_ok;
  logic               last_word;
  logic               push;
  entry_t             push_entry;
  logic               fifo_empty, fifo_full, pop, accept;
  entry_t             head;

`ifdef PHY_RX_CRC_CHECK_EN
  logic [15:0] crc_q, crc_d;

  // Bit-serial CRC-16-CCITT over one 16-bit word, MSB first.
  function automatic logic [15:0] crc16_word(input logic [15:0] crc, input logic [15:0] word);
    logic [15:0] c;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      c = {c[14:0], 1'b0} ^ ((c[15] ^ word[i]) ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction
`endif

  assign len_ok    = (bus.data_in != 16'd0) && (bus.data_in <= 16'(MAX_LEN));
  assign last_word = (cnt_q == CNT_W'(1));

  // FSM: state register. locked tracks the state it is entering so it is high
  // exactly while the FSM sits in HEADER/PAYLOAD/CRC.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q  <= S_HUNT;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      locked_q <= (state_d != S_HUNT);
    end
  end

  // FSM: next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    if (bus.in_valid) begin
      unique case (state_q)
        S_HUNT:    if (bus.data_in == SYNC_WORD) state_d = S_HEADER;
        S_HEADER:  state_d = len_ok ? S_PAYLOAD : S_HUNT;
`ifdef PHY_RX_CRC_CHECK_EN
        S_PAYLOAD: if (last_word) state_d = S_CRC;
        S_CRC:     state_d = S_HUNT;
`else
        S_PAYLOAD: if (last_word) state_d = S_HUNT;
`endif
        default:   state_d = S_HUNT;
      endcase
    end
  end

  // FSM: outputs and datapath next-state.
  always_comb begin
    cnt_d      = cnt_q;
    first_d    = first_q;
    err_d      = 1'b0;
    push       = 1'b0;
    push_entry = '{sof: first_q, eof: last_word, data: bus.data_in};
`ifdef PHY_RX_CRC_CHECK_EN
    crc_d      = crc_q;
`endif
    if (bus.in_valid) begin
      unique case (state_q)
        S_HUNT: begin
`ifdef PHY_RX_CRC_CHECK_EN
          if (bus.data_in == SYNC_WORD) crc_d = 16'hFFFF;
`endif
        end
        S_HEADER: begin
          if (len_ok) begin
            cnt_d   = bus.data_in[CNT_W-1:0];
            first_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
`ifdef PHY_RX_CRC_CHECK_EN
          crc_d = crc16_word(crc_q, bus.data_in);
`endif
        end
        S_PAYLOAD: begin
          push    = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
          first_d = 1'b0;
`ifdef PHY_RX_CRC_CHECK_EN
          crc_d   = crc16_word(crc_q, bus.data_in);
`endif
        end
`ifdef PHY_RX_CRC_CHECK_EN
        S_CRC: err_d = (bus.data_in != crc_q);
`endif
        default: ;
      endcase
    end
  end

  // FIFO bookkeeping: the extra pointer bit separates full from empty.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop        = !fifo_empty && bus.out_ready;
  assign accept     = push && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      first_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
`ifdef PHY_RX_CRC_CHECK_EN
      crc_q       <= '0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      frame_err_q <= err_d;
      if (push && !accept) overflow_q <= 1'b1;
      if (accept) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
`ifdef PHY_RX_CRC_CHECK_EN
      crc_q       <= crc_d;
`endif
    end
  end

  // NOTE: storage is deliberately not reset; emptiness comes from the pointers and outputs are gated.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_q[PTR_W-1:0]] <= push_entry;
  end

  assign head          = mem[rd_ptr_q[PTR_W-1:0]];
  assign bus.out_valid = !fifo_empty;
  assign bus.data_out  = fifo_empty ? 16'd0 : head.data;
  assign bus.out_sof   = !fifo_empty && head.sof;
  assign bus.out_eof   = !fifo_empty && head.eof;
  assign bus.locked    = locked_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overflow  = overflow_q;

endmodule
